pc_sequencer: RTL and testbench
===============================

Name: pc_sequencer

Overview:
- Controller that owns and sequences the program-counter register of the single-cycle/fetch datapath.
- Decides each cycle whether the PC holds, increments by 4, or is redirected by a branch or jump.
- Issues the instruction-memory fetch request and sequences boot, run and halt states.
- Sits between the decode/execute control signals and the instruction memory.

Parameters:
- WIDTH, 32, address width of PC and targets.
- RESET_VECTOR, 32'h0000_0000, PC value loaded on reset.
- TRAP_VECTOR, 32'h0000_0100, PC loaded on misaligned redirect (only with SEQ_TRAP_EN).

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- stall  in  1  hold PC this cycle; no fetch accepted.
- halt  in  1  request to enter HALT.
- branch_taken  in  1  conditional branch resolved taken this cycle.
- branch_target  in  WIDTH  branch destination.
- jump  in  1  unconditional jump this cycle.
- jump_target  in  WIDTH  jump destination.
- imem_ready  in  1  instruction memory accepts/returns the fetch this cycle.
- imem_req  out  1  fetch request for address pc.
- pc  out  WIDTH  current PC (registered).
- next_pc  out  WIDTH  value pc takes at next edge (combinational).
- pc_valid  out  1  pc's fetch accepted this cycle (fire).
- flush  out  1  redirect taken this cycle; downstream discards in-flight instruction.
- fetch_count  out  WIDTH  number of accepted fetches since reset.

Behaviour:
- Reset (async, immediate):
  - state=BOOT, pc=RESET_VECTOR, fetch_count=0.
  - imem_req=0, pc_valid=0, flush=0.
- FSM states: BOOT, RUN, HALT.
  - BOOT: imem_req=0; unconditionally goes to RUN next edge; pc unchanged.
  - RUN: imem_req = !stall.
    - fire = imem_req & imem_ready; pc_valid = fire.
    - halt=1 -> HALT next edge. A fire in the same cycle still completes and pc advances.
  - HALT: imem_req=0, pc held.
    - Leaves to RUN only on a redirect (jump or branch_taken); pc loads the target.
    - The halt input is ignored while in HALT.
- next_pc priority, evaluated in RUN and HALT:
  1. jump -> jump_target.
  2. branch_taken -> branch_target.
  3. fire -> pc + 4, wrapping modulo 2^WIDTH (32'hFFFF_FFFC -> 0).
  4. otherwise -> pc.
  - In BOOT, next_pc = pc.
- Redirect (jump|branch_taken, not in BOOT):
  - Applies at the next edge regardless of stall or imem_ready.
  - flush=1 combinationally that cycle.
  - Redirects asserted during BOOT are dropped.
- fetch_count:
  - Increments by 1 on each fire, including when fire coincides with a redirect.
  - Wraps at 2^WIDTH.
- Stall with no redirect: pc, state and fetch_count all held; imem_req=0.
- Simultaneous halt and redirect in RUN: the redirect is applied and halt wins the state, so the FSM enters HALT at the target PC.
- Latency:
  - Redirect target is visible on pc one cycle after assertion.
  - First imem_req is issued 1 cycle after reset deasserts.

Optional Feature:
- Macro SEQ_TRAP_EN.
- With the macro defined:
  - A redirect whose target[1:0] != 2'b00 loads TRAP_VECTOR instead of the target.
  - Extra output trap (1b) pulses high for that cycle.
  - Extra output trap_addr (WIDTH) registers the offending target; reset value 0.
  - flush is still asserted.
- Without the macro: targets load unmodified (the low bits pass through), and the trap and trap_addr ports do not exist.

Test Plan:
- Reset, then imem_ready=1 held for 4 cycles -> cycle1 imem_req=0 (BOOT), then pc = 0,4,8,C; fetch_count=3 after the third fire.
- Pulse rst mid-run at pc=0x10 -> pc immediately 0, state BOOT, fetch_count=0 without waiting for a clock edge.
- RUN at pc=0x20, stall=1 for 3 cycles with imem_ready=1 -> imem_req=0, pc stays 0x20, count frozen; pc=0x24 one cycle after stall drops.
- Same cycle jump=1 (0x400) and branch_taken=1 (0x200) at pc=0x8 -> flush=1, pc=0x400 next cycle.
- halt=1 at pc=0x30 with fire -> pc=0x34, state HALT, imem_req=0. After 5 idle cycles, branch_taken to 0x80 -> pc=0x80, RUN, imem_req=1.
- pc=32'hFFFF_FFFC with fire -> pc=0. With SEQ_TRAP_EN, jump to 0x102 -> pc=0x100, trap=1, trap_addr=0x102.

Source files
------------

// File: rtl/pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : pc_sequencer
// Description : Owns the program-counter register of the fetch datapath.
//               Each cycle it holds the PC, advances it by 4, or redirects it
//               to a branch/jump target. It also issues the instruction-memory
//               fetch request and sequences the BOOT -> RUN -> HALT states.
//               Optional build macro SEQ_TRAP_EN: when defined, a redirect to
//               a target that is not word aligned loads TRAP_VECTOR instead,
//               pulses trap and records the offending target in trap_addr.
// Revision    : 1.0 - initial release
// ============================================================================
module pc_sequencer #(
  parameter int               WIDTH        = 32,
  parameter logic [WIDTH-1:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [WIDTH-1:0] TRAP_VECTOR  = 32'h0000_0100
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             halt,
  input  logic             branch_taken,
  input  logic [WIDTH-1:0] branch_target,
  input  logic             jump,
  input  logic [WIDTH-1:0] jump_target,
  input  logic             imem_ready,
  output logic             imem_req,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] next_pc,
  output logic             pc_valid,
  output logic             flush,
`ifdef SEQ_TRAP_EN
  output logic             trap,
  output logic [WIDTH-1:0] trap_addr,
`endif
  output logic [WIDTH-1:0] fetch_count
);

  // Sequencer states.
  localparam logic [1:0] ST_BOOT = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_HALT = 2'd2;

  localparam logic [WIDTH-1:0] C_PC_STEP = WIDTH'(4);
  localparam logic [WIDTH-1:0] C_ONE     = WIDTH'(1);

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] count_q, count_d;

  logic             w_in_boot;
  logic             w_redirect;
  logic             w_fire;
  logic [WIDTH-1:0] w_raw_target;
  logic [WIDTH-1:0] w_eff_target;

`ifdef SEQ_TRAP_EN
  logic             w_trap;
  logic [WIDTH-1:0] trap_addr_q, trap_addr_d;
`endif

  // Fetch handshake and redirect detection; redirects are dropped in BOOT.
  always_comb begin
    w_in_boot    = (state_q == ST_BOOT);
    w_redirect   = (jump | branch_taken) & ~w_in_boot;
    imem_req     = (state_q == ST_RUN) & ~stall;
    w_fire       = imem_req & imem_ready;
    // Jump outranks a simultaneously taken branch.
    w_raw_target = jump ? jump_target : branch_target;
  end

`ifdef SEQ_TRAP_EN
  // A misaligned redirect is diverted to the trap handler and recorded.
  always_comb begin
    w_trap       = w_redirect & (w_raw_target[1:0] != 2'b00);
    w_eff_target = w_trap ? TRAP_VECTOR : w_raw_target;
    trap_addr_d  = w_trap ? w_raw_target : trap_addr_q;
  end
`else
  // Without trapping the selected target passes through untouched.
  always_comb begin
    w_eff_target = w_raw_target;
  end
`endif

  // Next-PC selection: redirect, then sequential advance, then hold.
  always_comb begin
    pc_d = pc_q;
    if (!w_in_boot) begin
      if (w_redirect) begin
        pc_d = w_eff_target;
      end else if (w_fire) begin
        pc_d = pc_q + C_PC_STEP;  // wraps modulo 2^WIDTH
      end
    end
  end

  // Accepted-fetch counter, counting fires even when they meet a redirect.
  always_comb begin
    count_d = count_q;
    if (w_fire) begin
      count_d = count_q + C_ONE;
    end
  end

  // State transitions; halt wins the state over a concurrent redirect, and a
  // stall without a redirect freezes the state along with the PC.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_BOOT: state_d = ST_RUN;
      ST_RUN: begin
        if (halt && !(stall && !w_redirect)) begin
          state_d = ST_HALT;
        end
      end
      ST_HALT: begin
        if (w_redirect) begin
          state_d = ST_RUN;
        end
      end
      default: state_d = ST_BOOT;
    endcase
  end

  // State, PC and counter registers with immediate reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_BOOT;
      pc_q    <= RESET_VECTOR;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      count_q <= count_d;
    end
  end

`ifdef SEQ_TRAP_EN
  // Offending-target capture register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      trap_addr_q <= '0;
    end else begin
      trap_addr_q <= trap_addr_d;
    end
  end

  // Trap outputs.
  always_comb begin
    trap      = w_trap;
    trap_addr = trap_addr_q;
  end
`endif

  // Remaining outputs.
  always_comb begin
    pc          = pc_q;
    next_pc     = pc_d;
    pc_valid    = w_fire;
    flush       = w_redirect;
    fetch_count = count_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_pc_sequencer
// Description : Self-checking bench for pc_sequencer. Directed steps followed
//               by randomized cycles, all compared against a behavioural model
//               of the sequencer. Honors SEQ_TRAP_EN when defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pc_sequencer;

  localparam logic [31:0] RESET_VEC = 32'h0000_0000;
  localparam logic [31:0] TRAP_VEC  = 32'h0000_0100;
  localparam int M_BOOT = 0;
  localparam int M_RUN  = 1;
  localparam int M_HALT = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0, halt = 1'b0, branch_taken = 1'b0, jump = 1'b0;
  logic        imem_ready = 1'b0;
  logic [31:0] branch_target = '0, jump_target = '0;
  logic        imem_req, pc_valid, flush;
  logic [31:0] pc, next_pc, fetch_count;
`ifdef SEQ_TRAP_EN
  logic        trap;
  logic [31:0] trap_addr;
`endif

  int passes = 0;
  int total  = 0;

  // Reference model state.
  int          m_mode;
  logic [31:0] m_pc;
  logic [31:0] m_cnt;
  logic [31:0] m_taddr;

  pc_sequencer #(
    .WIDTH(32), .RESET_VECTOR(RESET_VEC), .TRAP_VECTOR(TRAP_VEC)
  ) dut (
    .clk(clk), .rst(rst), .stall(stall), .halt(halt),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .jump(jump), .jump_target(jump_target), .imem_ready(imem_ready),
    .imem_req(imem_req), .pc(pc), .next_pc(next_pc), .pc_valid(pc_valid),
    .flush(flush),
`ifdef SEQ_TRAP_EN
    .trap(trap), .trap_addr(trap_addr),
`endif
    .fetch_count(fetch_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic model_reset();
    m_mode  = M_BOOT;
    m_pc    = RESET_VEC;
    m_cnt   = '0;
    m_taddr = '0;
  endtask

  // One clock cycle: drive at the falling edge, compare, then advance the model.
  task automatic cycle(input logic s, input logic h, input logic b, input logic [31:0] bt,
                       input logic j, input logic [31:0] jt, input logic r);
    logic        redir, req, fire, trapped;
    logic [31:0] tgt, eff, npc;
    stall = s; halt = h; branch_taken = b; branch_target = bt;
    jump = j; jump_target = jt; imem_ready = r;
    #1;
    redir   = (m_mode != M_BOOT) && (j || b);
    req     = (m_mode == M_RUN) && !s;
    fire    = req && r;
    tgt     = j ? jt : bt;
    trapped = 1'b0;
`ifdef SEQ_TRAP_EN
    trapped = redir && (tgt % 4 != 0);
`endif
    eff = trapped ? TRAP_VEC : tgt;
    if (m_mode == M_BOOT)  npc = m_pc;
    else if (redir)        npc = eff;
    else if (fire)         npc = m_pc + 32'd4;
    else                   npc = m_pc;
    check("pc", pc, m_pc);
    check("next_pc", next_pc, npc);
    check("imem_req", {31'b0, imem_req}, {31'b0, req});
    check("pc_valid", {31'b0, pc_valid}, {31'b0, fire});
    check("flush", {31'b0, flush}, {31'b0, redir});
    check("fetch_count", fetch_count, m_cnt);
`ifdef SEQ_TRAP_EN
    check("trap", {31'b0, trap}, {31'b0, trapped});
    check("trap_addr", trap_addr, m_taddr);
`endif
    @(posedge clk);
    m_pc = npc;
    if (fire) m_cnt = m_cnt + 32'd1;
    if (trapped) m_taddr = tgt;
    case (m_mode)
      M_BOOT: m_mode = M_RUN;
      M_RUN:  if (h && !(s && !redir)) m_mode = M_HALT;
      default: if (redir) m_mode = M_RUN;
    endcase
    @(negedge clk);
  endtask

  task automatic idle(input logic r);
    cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, r);
  endtask

  task automatic jump_to(input logic [31:0] a);
    cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, a, 1'b0);
  endtask

  initial begin
    // Power-on reset.
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Boot then three fires: pc 0,4,8,C.
    repeat (4) idle(1'b1);
    check("boot_pc_c", pc, 32'hC);
    check("boot_cnt3", fetch_count, 32'd3);
    idle(1'b1);
    check("pc_10", pc, 32'h10);

    // Asynchronous reset in mid-cycle, with a jump pending to prove flush masks.
    jump = 1'b1; jump_target = 32'h444;
    #2 rst = 1'b1;
    #1;
    check("arst_pc", pc, RESET_VEC);
    check("arst_cnt", fetch_count, 32'd0);
    check("arst_req", {31'b0, imem_req}, 32'd0);
    check("arst_flush", {31'b0, flush}, 32'd0);
    check("arst_valid", {31'b0, pc_valid}, 32'd0);
    jump = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    model_reset();

    // Redirect during BOOT is dropped.
    cycle(1'b0, 1'b0, 1'b1, 32'h500, 1'b1, 32'h600, 1'b1);
    check("boot_drop", pc, RESET_VEC);

    // Stall at 0x20.
    jump_to(32'h20);
    repeat (3) cycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
    check("stall_pc", pc, 32'h20);
    idle(1'b1);
    check("unstall_pc", pc, 32'h24);

    // Jump beats branch.
    jump_to(32'h8);
    cycle(1'b0, 1'b0, 1'b1, 32'h200, 1'b1, 32'h400, 1'b1);
    check("prio_pc", pc, 32'h400);

    // Halt with fire, idle, then branch out.
    jump_to(32'h30);
    cycle(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
    check("halt_pc", pc, 32'h34);
    repeat (5) cycle(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
    check("halt_hold", pc, 32'h34);
    cycle(1'b0, 1'b0, 1'b1, 32'h80, 1'b0, 32'h0, 1'b1);
    check("resume_pc", pc, 32'h80);
    idle(1'b1);

    // Halt together with a redirect lands in HALT at the target.
    cycle(1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 32'h700, 1'b1);
    check("halt_redir_pc", pc, 32'h700);
    idle(1'b1);
    check("halt_redir_hold", pc, 32'h700);

    // Wrap at the top of the address space.
    jump_to(32'hFFFF_FFFC);
    idle(1'b1);
    check("wrap_pc", pc, 32'h0);

    // Misaligned redirect.
    jump_to(32'h102);
`ifdef SEQ_TRAP_EN
    check("trap_pc", pc, TRAP_VEC);
    check("trap_addr_dir", trap_addr, 32'h102);
`else
    check("misalign_pc", pc, 32'h102);
`endif
    idle(1'b1);

    // Randomized cycles against the model.
    for (int i = 0; i < 400; i++) begin
      logic [31:0] bt, jt;
      bt = $urandom;
      jt = $urandom;
      if ($urandom_range(0, 3) != 0) bt[1:0] = 2'b00;
      if ($urandom_range(0, 3) != 0) jt[1:0] = 2'b00;
      cycle($urandom_range(0, 4) == 0, $urandom_range(0, 9) == 0,
            $urandom_range(0, 7) == 0, bt, $urandom_range(0, 9) == 0, jt,
            $urandom_range(0, 3) != 0);
    end

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
`default_nettype wire
